// File: rtl/seq_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, FSM states
// and instruction field positions.
package seq_pkg;

  localparam int INSTR_W = 12;

  localparam int OP_MSB   = 11;
  localparam int OP_LSB   = 9;
  localparam int DST_MSB  = 8;
  localparam int DST_LSB  = 7;
  localparam int SRCA_MSB = 6;
  localparam int SRCA_LSB = 5;
  localparam int SRCB_MSB = 4;
  localparam int SRCB_LSB = 3;
  localparam int IMM_MSB  = 3;
  localparam int IMM_LSB  = 0;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE,
    ST_HALT
  } state_t;

endpackage

// File: rtl/rf_sequencer_if.sv
// Instruction handshake plus register-file port bundle between the
// sequencer (master) and its environment (slave).
interface rf_sequencer_if #(
  parameter int DW = 4,
  parameter int AW = 2
);
  logic [11:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          rea;
  logic          reb;
  logic [AW-1:0] raa;
  logic [AW-1:0] rab;
  logic [DW-1:0] douta;
  logic [DW-1:0] doutb;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] din;
  logic          done;
  logic          zero;
  logic          carry;
  logic          halted;

  modport master (
    input  instr, instr_valid, douta, doutb,
    output instr_ready, rea, reb, raa, rab, we, wa, din, done, zero, carry, halted
  );

  modport slave (
    output instr, instr_valid, douta, doutb,
    input  instr_ready, rea, reb, raa, rab, we, wa, din, done, zero, carry, halted
  );
endinterface

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer; carry doubles as borrow on SUB.
module seq_alu
  import seq_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  // The extra top bit of the unsigned difference is set exactly when a < b.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_LDI: result = imm;
      OP_ADD: begin
        result = sum[DW-1:0];
        carry  = sum[DW];
      end
      OP_SUB: begin
        result = diff[DW-1:0];
        carry  = diff[DW];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_MOV: result = a;
      default: ;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/rf_sequencer.sv
// Four-phase instruction sequencer (read, execute, write back) driving the
// 4x4 register file; NOP retires in one cycle, HALT parks until reset.
module rf_sequencer
  import seq_pkg::*;
#(
  parameter int DW = 4,
  parameter int AW = 2
) (
  input logic           clk,
  input logic           rst,
  rf_sequencer_if.master bus
);

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [DW-1:0]        opa_q, opa_d;
  logic [DW-1:0]        opb_q, opb_d;
  logic [DW-1:0]        result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 nop_done_q, nop_done_d;

  logic [2:0]           op_q;
  logic [2:0]           op_in;
  logic [DW-1:0]        imm_q;
  logic [DW-1:0]        alu_result;
  logic                 alu_carry;
  logic                 alu_zero;
  logic                 flag_op;

  assign op_q    = instr_q[OP_MSB:OP_LSB];
  assign op_in   = bus.instr[OP_MSB:OP_LSB];
  assign imm_q   = DW'(instr_q[IMM_MSB:IMM_LSB]);
  assign flag_op = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                   (op_q == OP_AND) || (op_q == OP_OR);

  seq_alu #(.DW(DW)) u_alu (
    .op     (op_q),
    .a      (opa_q),
    .b      (opb_q),
    .imm    (imm_q),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    opa_d           = opa_q;
    opb_d           = opb_q;
    result_d        = result_q;
    zero_d          = zero_q;
    carry_d         = carry_q;
    nop_done_d      = 1'b0;
    bus.instr_ready = 1'b0;
    bus.rea         = 1'b0;
    bus.reb         = 1'b0;
    bus.raa         = '0;
    bus.rab         = '0;
    bus.we          = 1'b0;
    bus.wa          = '0;
    bus.din         = '0;
    bus.halted      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          case (op_in)
            OP_NOP:  nop_done_d = 1'b1;
            OP_HALT: state_d    = ST_HALT;
            default: state_d    = ST_READ;
          endcase
        end
      end
      ST_READ: begin
        bus.rea = 1'b1;
        bus.reb = 1'b1;
        bus.raa = AW'(instr_q[SRCA_MSB:SRCA_LSB]);
        bus.rab = AW'(instr_q[SRCB_MSB:SRCB_LSB]);
        opa_d   = bus.douta;
        opb_d   = bus.doutb;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        result_d = alu_result;
        if (flag_op) begin
          zero_d  = alu_zero;
          carry_d = alu_carry;
        end
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        bus.we  = 1'b1;
        bus.wa  = AW'(instr_q[DST_MSB:DST_LSB]);
        bus.din = result_q;
        state_d = ST_IDLE;
      end
      ST_HALT: bus.halted = 1'b1;
      default: state_d = ST_IDLE;
    endcase
    bus.done  = (state_q == ST_WRITE) || nop_done_q;
    bus.zero  = zero_q;
    bus.carry = carry_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      nop_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      nop_done_q <= nop_done_d;
    end
  end

endmodule
